// File: rtl/classificador_cores.sv
// Per-quadrant RGB565 averaging and cube-colour classification for nine facelets.
// Optional build macro CLASSIFICADOR_TIMEOUT_EN ends a frame after TIMEOUT idle cycles.
module classificador_cores #(
   parameter int unsigned S_CONT  = 8,
   parameter int unsigned TIMEOUT = 1048576
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        iniciar,
   input  logic        pixel_valido,
   input  logic [15:0] pixel,
   input  logic [3:0]  quadrante,
   input  logic        fim_frame,
   output logic [26:0] cores,
   output logic        pronto,
   output logic        ocupado,
   output logic [3:0]  db_estado
);

   localparam int unsigned RW = 5 + S_CONT;
   localparam int unsigned GW = 6 + S_CONT;
   localparam int unsigned CW = S_CONT + 1;

   typedef enum logic [1:0] {
      OCIOSO     = 2'd0,
      ACUMULA    = 2'd1,
      CLASSIFICA = 2'd2,
      PRONTO     = 2'd3
   } estado_t;

   estado_t r_estado, w_proximo;

   logic [RW-1:0] r_sr  [0:8];
   logic [GW-1:0] r_sg  [0:8];
   logic [RW-1:0] r_sb  [0:8];
   logic [CW-1:0] r_cnt [0:8];
   logic [3:0]    r_idx;
   logic [26:0]   r_cores;

   logic [3:0]    w_qp;
   logic          w_aceita;
   logic          w_fim;
   logic [3:0]    w_ci;
   logic [RW-1:0] w_r;
   logic [GW-1:0] w_g5;
   logic [RW-1:0] w_b;
   logic          w_cheio;
   logic [2:0]    w_codigo;

   if (TIMEOUT < 1) begin : g_timeout_invalido
      $error("TIMEOUT must be at least 1");
   end

   assign w_qp     = (quadrante < 4'd9) ? quadrante : 4'd0;
   assign w_aceita = pixel_valido && !iniciar && (r_estado == ACUMULA) &&
                     (quadrante < 4'd9) && !r_cnt[w_qp][S_CONT];

`ifdef CLASSIFICADOR_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] r_ocioso;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_ocioso <= '0;
      else if (iniciar || w_aceita || (r_estado != ACUMULA))
         r_ocioso <= '0;
      else
         r_ocioso <= r_ocioso + 1'b1;
   end

   // Expiry acts exactly like a fim_frame pulse on the same edge.
   assign w_fim = fim_frame ||
                  ((r_estado == ACUMULA) && !w_aceita && (r_ocioso == TW'(TIMEOUT - 1)));
`else
   assign w_fim = fim_frame;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_estado <= OCIOSO;
      else
         r_estado <= w_proximo;
   end

   always_comb begin
      w_proximo = r_estado;
      if (iniciar) begin
         w_proximo = ACUMULA;
      end else begin
         case (r_estado)
            ACUMULA:    if (w_fim) w_proximo = CLASSIFICA;
            CLASSIFICA: if (r_idx == 4'd9) w_proximo = PRONTO;
            default:    w_proximo = r_estado;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 9; i++) begin
            r_sr[i]  <= '0;
            r_sg[i]  <= '0;
            r_sb[i]  <= '0;
            r_cnt[i] <= '0;
         end
      end else if (iniciar) begin
         for (int unsigned i = 0; i < 9; i++) begin
            r_sr[i]  <= '0;
            r_sg[i]  <= '0;
            r_sb[i]  <= '0;
            r_cnt[i] <= '0;
         end
      end else if (w_aceita) begin
         r_sr[w_qp]  <= r_sr[w_qp] + RW'(pixel[15:11]);
         r_sg[w_qp]  <= r_sg[w_qp] + GW'(pixel[10:5]);
         r_sb[w_qp]  <= r_sb[w_qp] + RW'(pixel[4:0]);
         r_cnt[w_qp] <= r_cnt[w_qp] + 1'b1;
      end
   end

   // Index 9 is a spare cycle so that pronto lands ten edges after fim_frame.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_idx <= '0;
      else if ((r_estado == CLASSIFICA) && !iniciar)
         r_idx <= r_idx + 1'b1;
      else
         r_idx <= '0;
   end

   assign w_ci    = (r_idx < 4'd9) ? r_idx : 4'd0;
   assign w_r     = r_sr[w_ci] >> S_CONT;
   assign w_g5    = r_sg[w_ci] >> (S_CONT + 1);
   assign w_b     = r_sb[w_ci] >> S_CONT;
   assign w_cheio = r_cnt[w_ci][S_CONT];

   always_comb begin
      w_codigo = 3'd7;
      if (!w_cheio)
         w_codigo = 3'd6;
      else if (w_r >= RW'(20) && w_g5 >= GW'(20) && w_b >= RW'(20))
         w_codigo = 3'd0;
      else if (w_r >= RW'(20) && w_g5 >= GW'(20) && w_b < RW'(12))
         w_codigo = 3'd1;
      else if (w_r >= RW'(20) && w_g5 >= GW'(10) && w_g5 < GW'(20) && w_b < RW'(12))
         w_codigo = 3'd2;
      else if (w_r >= RW'(16) && w_g5 < GW'(10) && w_b < RW'(12))
         w_codigo = 3'd3;
      else if (w_g5 >= GW'(16) && w_r < RW'(12) && w_b < RW'(16))
         w_codigo = 3'd4;
      else if (w_b >= RW'(16) && w_r < RW'(12) && w_g5 < GW'(16))
         w_codigo = 3'd5;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cores <= '1;
      end else if ((r_estado == CLASSIFICA) && !iniciar) begin
         for (int unsigned i = 0; i < 9; i++) begin
            if (r_idx == 4'(i))
               r_cores[3*i +: 3] <= w_codigo;
         end
      end
   end

   assign cores     = r_cores;
   assign pronto    = (r_estado == PRONTO);
   assign ocupado   = (r_estado == ACUMULA) || (r_estado == CLASSIFICA);
   assign db_estado = {2'b00, r_estado};

endmodule
